// File: rtl/speed_unit_converter.sv
// Streaming NMEA speed-field parser: ASCII digits in, rounded x100 knots/mph/km/h out
// as binary and BCD over a valid/ready handshake.
module speed_unit_converter #(
  parameter int unsigned MAX_INT_DIGITS = 3,
  parameter int unsigned FRAC_DIGITS    = 2,
  parameter int unsigned VAL_W          = 20,
  parameter int unsigned OUT_DIGITS     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  input  logic [1:0]              unit_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VAL_W-1:0]        out_value,
  output logic [4*OUT_DIGITS-1:0] out_bcd,
  output logic                    out_err,
  output logic                    out_ovf
);
  localparam int unsigned BCD_W   = 4 * OUT_DIGITS;
  localparam int unsigned PROD_W  = VAL_W + 11;
  localparam int unsigned IC_W    = $clog2(MAX_INT_DIGITS + 1);
  localparam int unsigned FC_W    = $clog2(FRAC_DIGITS + 1);
  localparam int unsigned BC_W    = $clog2(VAL_W);
  localparam int unsigned MAX_OUT = 10 ** OUT_DIGITS - 1;

  localparam logic [2:0] S_PARSE = 3'd0;
  localparam logic [2:0] S_SKIP  = 3'd1;
  localparam logic [2:0] S_SCALE = 3'd2;
  localparam logic [2:0] S_BCD   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [VAL_W-1:0] acc;
  logic [IC_W-1:0]  int_cnt;
  logic [FC_W-1:0]  frac_cnt;
  logic             frac_mode;
  logic             started;
  logic [1:0]       unit_q;
  logic             err_q;
  logic [VAL_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_sh;
  logic [BC_W-1:0]  bit_cnt;

  logic             accept, is_digit, is_dot, is_delim, field_err;
  logic [1:0]       unit_eff;
  logic [VAL_W-1:0] digit, acc_pad, res;
  logic [PROD_W-1:0] k_sel, prod, res_full;
  logic             sat;
  logic [BCD_W-1:0] bcd_adj, bcd_step;
  logic [VAL_W-1:0] bin_step;
  logic [3:0]       nib;

  assign in_ready  = (state == S_PARSE) || (state == S_SKIP);
  assign accept    = in_valid && in_ready;
  assign is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_dot    = (in_char == 8'h2E);
  assign is_delim  = (in_char == 8'h2C) || (in_char == 8'h2A);
  assign digit     = VAL_W'(in_char[3:0]);
  // Unit is latched with the first char; a lone delimiter still sees the live value.
  assign unit_eff  = started ? unit_q : unit_sel;
  assign field_err = (state == S_SKIP) || ((int_cnt == '0) && (frac_cnt == '0)) ||
                     (unit_eff == 2'd3);

  // Pad missing fraction digits with x10 each
  always_comb begin
    acc_pad = acc;
    for (int i = 0; i < int'(FRAC_DIGITS); i++) begin
      if (FC_W'(i) >= frac_cnt) acc_pad = acc_pad * VAL_W'(10);
    end
  end

  // Unit scaling with round-half-up and saturation
  always_comb begin
    case (unit_q)
      2'd0:    k_sel = PROD_W'(1000);
      2'd1:    k_sel = PROD_W'(1151);
      default: k_sel = PROD_W'(1852);
    endcase
    prod     = PROD_W'(acc) * k_sel + PROD_W'(500);
    res_full = prod / PROD_W'(1000);
    sat      = res_full > PROD_W'(MAX_OUT);
    res      = sat ? VAL_W'(MAX_OUT) : VAL_W'(res_full);
  end

  // One double-dabble step: add-3 on nibbles >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd_sh;
    nib     = 4'd0;
    for (int i = 0; i < int'(OUT_DIGITS); i++) begin
      nib = bcd_sh[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_adj[4*i +: 4] = nib;
    end
    bcd_step = {bcd_adj[BCD_W-2:0], bin_sh[VAL_W-1]};
    bin_step = {bin_sh[VAL_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_PARSE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_PARSE: begin
        if (accept) begin
          if (is_delim) state_nxt = S_SCALE;
          else if (is_dot) begin
            if (frac_mode) state_nxt = S_SKIP;
          end else if (is_digit) begin
            if (!frac_mode && (int_cnt == IC_W'(MAX_INT_DIGITS))) state_nxt = S_SKIP;
          end else state_nxt = S_SKIP;
        end
      end
      S_SKIP:  if (accept && is_delim) state_nxt = S_SCALE;
      S_SCALE: state_nxt = err_q ? S_OUT : S_BCD;
      S_BCD:   if (bit_cnt == BC_W'(VAL_W - 1)) state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_PARSE;
      default: state_nxt = S_PARSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      int_cnt   <= '0;
      frac_cnt  <= '0;
      frac_mode <= 1'b0;
      started   <= 1'b0;
      unit_q    <= 2'd0;
      err_q     <= 1'b0;
      bin_sh    <= '0;
      bcd_sh    <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_bcd   <= '0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        S_PARSE: begin
          if (accept) begin
            if (!started) begin
              started <= 1'b1;
              unit_q  <= unit_sel;
            end
            if (is_delim) begin
              acc   <= acc_pad;
              err_q <= field_err;
            end else if (is_digit) begin
              if (!frac_mode) begin
                if (int_cnt != IC_W'(MAX_INT_DIGITS)) begin
                  acc     <= acc * VAL_W'(10) + digit;
                  int_cnt <= int_cnt + IC_W'(1);
                end
              end else if (frac_cnt < FC_W'(FRAC_DIGITS)) begin
                acc      <= acc * VAL_W'(10) + digit;
                frac_cnt <= frac_cnt + FC_W'(1);
              end
            end else if (is_dot) begin
              frac_mode <= 1'b1;
            end
          end
        end
        S_SKIP: if (accept && is_delim) err_q <= 1'b1;
        S_SCALE: begin
          if (err_q) begin
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_ovf   <= 1'b0;
            out_value <= '0;
            out_bcd   <= '0;
          end else begin
            out_value <= res;
            out_ovf   <= sat;
            out_err   <= 1'b0;
            bin_sh    <= res;
            bcd_sh    <= '0;
            bit_cnt   <= '0;
          end
        end
        S_BCD: begin
          bin_sh  <= bin_step;
          bcd_sh  <= bcd_step;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(VAL_W - 1)) begin
            out_bcd   <= bcd_step;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            int_cnt   <= '0;
            frac_cnt  <= '0;
            frac_mode <= 1'b0;
            started   <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_speed_unit_converter.sv
// Directed bench for speed_unit_converter: vector table plus back-pressure,
// mid-field unit change and reset-abort sequences. A 5-digit instance covers saturation.
module tb_speed_unit_converter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic [1:0]  unit_sel = 2'd0;

  logic        in_ready, out_valid, out_err, out_ovf;
  logic [19:0] out_value;
  logic [23:0] out_bcd;
  logic        in_ready5, out_valid5, out_err5, out_ovf5;
  logic [19:0] out_value5;
  logic [19:0] out_bcd5;

  speed_unit_converter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .unit_sel(unit_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_bcd(out_bcd), .out_err(out_err), .out_ovf(out_ovf)
  );

  speed_unit_converter #(.OUT_DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .in_char(in_char),
    .unit_sel(unit_sel), .out_valid(out_valid5), .out_ready(out_ready),
    .out_value(out_value5), .out_bcd(out_bcd5), .out_err(out_err5), .out_ovf(out_ovf5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int e_last = 0;

  typedef struct {
    string       fld;
    logic [1:0]  unit;
    int          val;
    logic [23:0] bcd;
    bit          err;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge with in_valid low.
  task automatic put_char(input byte c);
    int t = 0;
    in_char  = c;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready timeout", 0, 1);
    @(posedge clk);
    #1 e_last = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_field(input string s, input logic [1:0] u);
    unit_sel = u;
    for (int i = 0; i < s.len(); i++) put_char(s[i]);
  endtask

  // lat < 0 skips the latency check (result already waiting)
  task automatic check_result(input string name, input int val, input logic [23:0] bcd,
                              input bit err, input int lat);
    int t = 0;
    int exp5;
    logic [19:0] bcd5;
    bit sat5;
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({name, " valid"}, out_valid, 1);
    if (out_valid) begin
      if (lat >= 0) chk({name, " latency"}, cyc - e_last, lat);
      chk({name, " value"}, out_value, val);
      chk({name, " bcd"}, out_bcd, bcd);
      chk({name, " err"}, out_err, err);
      chk({name, " ovf"}, out_ovf, 0);
      sat5 = !err && (val > 99999);
      exp5 = err ? 0 : (sat5 ? 99999 : val);
      bcd5 = err ? 20'h0 : (sat5 ? 20'h99999 : bcd[19:0]);
      chk({name, " valid5"}, out_valid5, 1);
      chk({name, " value5"}, out_value5, exp5);
      chk({name, " bcd5"}, out_bcd5, bcd5);
      chk({name, " ovf5"}, out_ovf5, sat5);
      chk({name, " err5"}, out_err5, err);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " valid drop"}, out_valid, 0);
    chk({name, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vecs.push_back(vec_t'{"3.45,",   2'd1, 397,    24'h000397, 1'b0, 21});
    vecs.push_back(vec_t'{"12.3,",   2'd2, 2278,   24'h002278, 1'b0, 21});
    vecs.push_back(vec_t'{"5.678,",  2'd0, 567,    24'h000567, 1'b0, 21});
    vecs.push_back(vec_t'{"7,",      2'd0, 700,    24'h000700, 1'b0, 21});
    vecs.push_back(vec_t'{"1..2,",   2'd0, 0,      24'h000000, 1'b1, 1});
    vecs.push_back(vec_t'{",",       2'd0, 0,      24'h000000, 1'b1, 1});
    vecs.push_back(vec_t'{"1234.5,", 2'd0, 0,      24'h000000, 1'b1, 1});
    vecs.push_back(vec_t'{"4.5,",    2'd3, 0,      24'h000000, 1'b1, 1});
    vecs.push_back(vec_t'{"12a.5,",  2'd1, 0,      24'h000000, 1'b1, 1});
    vecs.push_back(vec_t'{"999.99,", 2'd2, 185198, 24'h185198, 1'b0, 21});
    vecs.push_back(vec_t'{".5*",     2'd0, 50,     24'h000050, 1'b0, 21});
    vecs.push_back(vec_t'{"0.01,",   2'd2, 2,      24'h000002, 1'b0, 21});
    vecs.push_back(vec_t'{"1.23,",   2'd1, 142,    24'h000142, 1'b0, 21});
    vecs.push_back(vec_t'{"0.5,",    2'd1, 58,     24'h000058, 1'b0, 21});

    repeat (3) @(negedge clk);
    chk("in_ready during reset", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_value", out_value, 0);
    chk("reset out_bcd", out_bcd, 0);
    chk("reset out_err", out_err, 0);
    chk("reset out_ovf", out_ovf, 0);

    foreach (vecs[i]) begin
      send_field(vecs[i].fld, vecs[i].unit);
      check_result(vecs[i].fld, vecs[i].val, vecs[i].bcd, vecs[i].err, vecs[i].lat);
    end

    // Back-pressure: result held, offered char not consumed
    send_field("3.45,", 2'd1);
    for (int t = 0; t < 60 && !out_valid; t++) @(negedge clk);
    in_char  = 8'h37;
    in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp valid", out_valid, 1);
      chk("bp value", out_value, 397);
      chk("bp bcd", out_bcd, 24'h000397);
      chk("bp in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check_result("bp release", 397, 24'h000397, 1'b0, -1);
    send_field(",", 2'd0);
    check_result("after bp empty", 0, 24'h000000, 1'b1, 1);

    // Unit changed mid-field is ignored
    unit_sel = 2'd0;
    put_char(8'h31);
    unit_sel = 2'd2;
    put_char(8'h2E);
    put_char(8'h30);
    unit_sel = 2'd3;
    put_char(8'h30);
    put_char(8'h2C);
    check_result("unit latch", 100, 24'h000100, 1'b0, 21);

    // Reset during BCD aborts the result
    send_field("9.99,", 2'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst abort no valid", seen, 0);
    chk("rst abort value", out_value, 0);
    chk("rst abort in_ready", in_ready, 1);
    send_field("1.00,", 2'd0);
    check_result("after rst", 100, 24'h000100, 1'b0, 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
